carry_skip_adder_pipelined: RTL and testbench
=============================================

// Module: carry_skip_adder_pipelined
// PURPOSE
//  Parametrised, pipelined carry-skip adder/subtractor; next generation of the 32-bit 4-bit-block design.
//  Splits WIDTH into BLOCK-bit carry-skip groups, distributes groups over STAGES register stages, and
//  moves operands through a valid/ready stream interface with backpressure.
//  Adds a subtract mode and a signed-overflow flag. Sits on the datapath between operand FIFO and ALU writeback.
// PARAMETERS
//  WIDTH   32  operand/sum width in bits
//  BLOCK    4  bits per carry-skip group; WIDTH % BLOCK == 0
//  STAGES   2  pipeline register stages = latency; (WIDTH/BLOCK) % STAGES == 0, STAGES >= 1
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid this cycle
//  in_ready   out  1      block accepts operands this cycle
//  in_a       in   WIDTH  operand A
//  in_b       in   WIDTH  operand B
//  in_cin     in   1      carry in
//  in_sub     in   1      1 = subtract (A - B), 0 = add
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  out_sum    out  WIDTH  result
//  out_cout   out  1      carry out of MSB group
//  out_ovf    out  1      two's-complement signed overflow
// BEHAVIOUR
//  - Elaboration fails if parameter divisibility rules are violated.
//  - Operand prep: b_eff = in_sub ? ~in_b : in_b; c0 = in_cin ^ in_sub.
//  - Group g: ripple sum, prop_g = &(a^b) over group; carry_out_g = prop_g ? carry_in_g : ripple_cout_g.
//  - Stage s computes groups [s*GPS, (s+1)*GPS-1], GPS = (WIDTH/BLOCK)/STAGES; registers its sum slice,
//    the inter-stage carry, and forwards remaining operand bits. Lower sum slices travel with the token.
//  - Transfer on a side: valid && ready at rising clk edge.
//  - Global stall: advance = !out_valid || out_ready; in_ready = advance (combinational from out_valid, out_ready).
//    When advance = 0 all stage registers and their valid bits hold.
//  - Bubbles: a stage with valid bit 0 carries no token; in_valid = 0 while advancing inserts a bubble.
//  - Latency: a token accepted at edge N appears with out_valid = 1 after edge N+STAGES-1, so it is visible
//    during the STAGES-th cycle after acceptance. Throughput: 1 token/cycle when out_ready is held at 1.
//  - Ordering strictly FIFO; no token dropped or duplicated under any out_ready pattern.
//  - Outputs held stable while out_valid && !out_ready.
//  - out_cout = carry out of top group (for sub: 1 = no borrow).
//  - out_ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]).
//  - Reset (rst_n = 0, any time, including mid-stream): all stage valid bits clear to 0 immediately.
//    Result: out_valid = 0, out_sum = 0, out_cout = 0, out_ovf = 0. In-flight tokens are discarded.
//    in_ready = 1 during reset and after release.
//  - Simultaneous out handshake and in handshake in the same cycle: both complete; pipeline shifts by one.
//  - STAGES = 1: single register stage; latency 1; whole carry-skip chain lies in one cycle.
// TESTING (WIDTH=32, BLOCK=4, STAGES=2, latency 2)
//  1. a=0xFFFFFFFF b=0x00000001 cin=0 sub=0 -> sum=0x00000000 cout=1 ovf=0; out_valid 2 edges after accept.
//  2. a=0x00000005 b=0x00000007 cin=0 sub=1 -> sum=0xFFFFFFFE cout=0 ovf=0.
//  3. a=0x7FFFFFFF b=0x00000001 cin=0 sub=0 -> sum=0x80000000 cout=0 ovf=1; a=0x80000000 b=1 sub=1 -> 0x7FFFFFFF ovf=1.
//  4. All-propagate skip path: a=0xAAAAAAAA b=0x55555555 cin=1 sub=0 -> sum=0x00000000 cout=1 ovf=0.
//  5. Backpressure: 4 back-to-back tokens; out_ready=0 for 3 cycles from first out_valid
//     -> in_ready=0 during the stall, out_sum stable, all 4 results emerge in order, none lost.
//  6. Reset with 2 tokens in flight -> out_valid=0 and out_sum=0 immediately; no stale result after release;
//     first new token returns its correct result at latency 2.

Source files
------------

// File: rtl/carry_skip_adder_pipelined.sv
// carry_skip_adder_pipelined: pipelined carry-skip adder/subtractor with valid/ready stream and global stall
module carry_skip_adder_pipelined #(
   parameter int WIDTH  = 32,
   parameter int BLOCK  = 4,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf
);
   localparam int GROUPS = WIDTH / BLOCK;
   localparam int GPS    = GROUPS / STAGES;
   localparam int SW     = GPS * BLOCK;

   if (STAGES < 1 || WIDTH % BLOCK != 0 || GROUPS % STAGES != 0) begin : g_bad_params
      $error("carry_skip_adder_pipelined: illegal WIDTH/BLOCK/STAGES combination");
   end

   logic advance;

   assign advance  = !out_valid || out_ready;
   assign in_ready = advance;

   for (genvar s = 0; s < STAGES; s++) begin : g_st
      // a/b shrink per stage: only the bits of groups not yet summed are carried forward
      localparam int RW = WIDTH - s * SW;
      localparam int LW = (s + 1) * SW;
      logic [RW-1:0] a_i, b_i;
      logic          c_i, v_i, c_d, c_q, v_q;
      logic [SW-1:0] ss;
      logic [LW-1:0] sum_d, sum_q;
      logic [GPS:0]  cg;
      if (s == 0) begin : g_in
         assign a_i   = in_a;
         assign b_i   = in_sub ? ~in_b : in_b;
         assign c_i   = in_cin ^ in_sub;
         assign v_i   = in_valid;
         assign sum_d = ss;
      end else begin : g_in
         assign a_i   = g_st[s-1].g_fwd.a_q;
         assign b_i   = g_st[s-1].g_fwd.b_q;
         assign c_i   = g_st[s-1].c_q;
         assign v_i   = g_st[s-1].v_q;
         assign sum_d = {ss, g_st[s-1].sum_q};
      end
      assign cg[0] = c_i;
      assign c_d   = cg[GPS];
      for (genvar g = 0; g < GPS; g++) begin : g_grp
         logic [BLOCK-1:0] p, gn;
         logic [BLOCK:0]   rc;
         assign p     = a_i[g*BLOCK +: BLOCK] ^ b_i[g*BLOCK +: BLOCK];
         assign gn    = a_i[g*BLOCK +: BLOCK] & b_i[g*BLOCK +: BLOCK];
         assign rc[0] = cg[g];
         for (genvar j = 0; j < BLOCK; j++) begin : g_bit
            assign rc[j+1] = gn[j] | (p[j] & rc[j]);
         end
         assign ss[g*BLOCK +: BLOCK] = p ^ rc[BLOCK-1:0];
         assign cg[g+1] = &p ? cg[g] : rc[BLOCK];
      end
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            sum_q <= '0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
         end else if (advance) begin
            sum_q <= sum_d;
            c_q   <= c_d;
            v_q   <= v_i;
         end
      end
      if (s < STAGES - 1) begin : g_fwd
         logic [RW-SW-1:0] a_q, b_q;
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               a_q <= '0;
               b_q <= '0;
            end else if (advance) begin
               a_q <= a_i[RW-1:SW];
               b_q <= b_i[RW-1:SW];
            end
         end
      end else begin : g_last
         logic ovf_d, ovf_q;
         assign ovf_d = (a_i[RW-1] == b_i[RW-1]) && (sum_d[LW-1] != a_i[RW-1]);
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) ovf_q <= 1'b0;
            else if (advance) ovf_q <= ovf_d;
         end
      end
   end

   assign out_valid = g_st[STAGES-1].v_q;
   assign out_sum   = g_st[STAGES-1].sum_q;
   assign out_cout  = g_st[STAGES-1].c_q;
   assign out_ovf   = g_st[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_carry_skip_adder_pipelined.sv
// tb_carry_skip_adder_pipelined: directed vectors with queue scoreboard for the pipelined carry-skip adder
module tb_carry_skip_adder_pipelined;
   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, in_cin, in_sub;
   logic [31:0] in_a, in_b;
   logic        out_valid, out_ready, out_cout, out_ovf;
   logic [31:0] out_sum;

   typedef struct packed {
      logic [31:0] sum;
      logic        cout;
      logic        ovf;
   } res_t;

   typedef struct packed {
      logic [31:0] a, b;
      logic        cin, sub;
      logic [31:0] sum;
      logic        cout, ovf;
   } vec_t;

   res_t exp_q[$];
   res_t e_mon;
   int   checks = 0;
   int   errors = 0;

   vec_t vecs [6] = '{
      '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0},
      '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1},
      '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1},
      '{32'hAAAAAAAA, 32'h55555555, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0},
      '{32'h12345678, 32'h87654321, 1'b0, 1'b0, 32'h99999999, 1'b0, 1'b0},
      '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000006, 1'b1, 1'b0}
   };

   vec_t bp [4] = '{
      '{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0},
      '{32'h00000100, 32'h00000200, 1'b0, 1'b0, 32'h00000300, 1'b0, 1'b0},
      '{32'h0000FFFF, 32'h00000001, 1'b0, 1'b0, 32'h00010000, 1'b0, 1'b0},
      '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1}
   };

   carry_skip_adder_pipelined #(.WIDTH(32), .BLOCK(4), .STAGES(2)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .in_sub(in_sub),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sum(out_sum), .out_cout(out_cout), .out_ovf(out_ovf)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input vec_t v);
      bit ok = 1'b0;
      in_a = v.a; in_b = v.b; in_cin = v.cin; in_sub = v.sub; in_valid = 1'b1;
      for (int t = 0; t < 100; t++) begin
         @(negedge clk);
         if (in_ready) begin
            ok = 1'b1;
            break;
         end
      end
      if (ok) exp_q.push_back('{sum: v.sum, cout: v.cout, ovf: v.ovf});
      else chk("accept_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int t = 0; t < 100 && exp_q.size() != 0; t++) begin
         @(posedge clk); #1;
      end
      chk("drain_pending", exp_q.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_out: got sum %h with no token outstanding at %0t", out_sum, $time);
         end else begin
            e_mon = exp_q.pop_front();
            chk("sum", out_sum, e_mon.sum);
            chk("cout", {31'd0, out_cout}, {31'd0, e_mon.cout});
            chk("ovf", {31'd0, out_ovf}, {31'd0, e_mon.ovf});
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", out_valid, 0);
      chk("rst_sum", out_sum, 0);
      chk("rst_cout", out_cout, 0);
      chk("rst_ovf", out_ovf, 0);
      chk("rst_in_ready", in_ready, 1);
      rst_n = 1'b1;
      @(posedge clk); #1;
      send('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
      chk("lat_first_cycle", out_valid, 0);
      @(posedge clk); #1;
      chk("lat_second_cycle", out_valid, 1);
      drain();
      for (int i = 0; i < 6; i++) send(vecs[i]);
      drain();
      fork
         begin
            for (int i = 0; i < 4; i++) send(bp[i]);
         end
         begin
            bit seen = 1'b0;
            out_ready = 1'b0;
            for (int t = 0; t < 20; t++) begin
               @(posedge clk); #1;
               if (out_valid) begin
                  seen = 1'b1;
                  break;
               end
            end
            chk("bp_first_valid", seen, 1);
            for (int k = 0; k < 3; k++) begin
               chk("bp_in_ready", in_ready, 0);
               chk("bp_stable_sum", out_sum, 32'h00000003);
               chk("bp_hold_valid", out_valid, 1);
               @(posedge clk); #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();
      send('{32'h00000011, 32'h00000022, 1'b0, 1'b0, 32'h00000033, 1'b0, 1'b0});
      send('{32'h00000033, 32'h00000044, 1'b0, 1'b0, 32'h00000077, 1'b0, 1'b0});
      chk("rst_inflight_valid", out_valid, 1);
      rst_n = 1'b0;
      exp_q.delete();
      #1;
      chk("midrst_valid", out_valid, 0);
      chk("midrst_sum", out_sum, 0);
      chk("midrst_cout", out_cout, 0);
      chk("midrst_in_ready", in_ready, 1);
      @(posedge clk); #1;
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk); #1;
         chk("post_rst_no_stale", out_valid, 0);
      end
      send('{32'h0F0F0F0F, 32'hF0F0F0F0, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0});
      chk("post_rst_lat1", out_valid, 0);
      @(posedge clk); #1;
      chk("post_rst_lat2", out_valid, 1);
      drain();
      repeat (3) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
